// File: rtl/lbdr_pkg.sv
// rtl/lbdr_pkg.sv - shared flit, port and state types for the LBDR routing unit
package lbdr_pkg;

    localparam logic [2:0] HEADER = 3'b001;
    localparam logic [2:0] BODY   = 3'b010;
    localparam logic [2:0] TAIL   = 3'b100;

    typedef enum logic [1:0] {
        N = 2'd0,
        E = 2'd1,
        W = 2'd2,
        S = 2'd3
    } port_idx_e;

    localparam int L_IDX = 4;

    // Bit order {L,S,W,E,N}, matching port_idx_e for the mesh ports
    typedef logic [4:0] port_vec_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUTED = 2'd1,
        LAST   = 2'd2
    } state_e;

endpackage

// File: rtl/lbdr_route_calc.sv
// rtl/lbdr_route_calc.sv - combinational LBDR legal-set, select and deroute logic
module lbdr_route_calc
    import lbdr_pkg::*;
#(
    parameter int X_W     = 2,
    parameter int Y_W     = 2,
    parameter bit FORK_EN = 1'b0,
    parameter bit DR_EN   = 1'b1
) (
    input  logic [7:0]       rxy,
    input  logic [3:0]       cx,
    input  logic [1:0]       dr,
    input  logic [X_W+Y_W-1:0] cur_addr,
    input  logic [X_W+Y_W-1:0] dst_addr,
    output port_vec_t        sel,
    output logic             unroutable
);

    localparam int AW = X_W + Y_W;

    logic [X_W-1:0] x_cur, x_dst;
    logic [Y_W-1:0] y_cur, y_dst;
    logic           n1, s1, e1, w1;
    logic           rne, rnw, ren, res, rwn, rws, rse, rsw;
    logic [3:0]     legal;
    logic           local_hit;

    assign x_cur = cur_addr[X_W-1:0];
    assign x_dst = dst_addr[X_W-1:0];
    assign y_cur = cur_addr[AW-1:X_W];
    assign y_dst = dst_addr[AW-1:X_W];

    assign n1 = y_dst < y_cur;
    assign s1 = y_cur < y_dst;
    assign e1 = x_cur < x_dst;
    assign w1 = x_dst < x_cur;

    assign {rsw, rse, rws, rwn, res, ren, rnw, rne} = rxy;

    assign legal[N] = (n1 & ~e1 & ~w1 | n1 & e1 & rne | n1 & w1 & rnw) & cx[N];
    assign legal[E] = (e1 & ~n1 & ~s1 | e1 & n1 & ren | e1 & s1 & res) & cx[E];
    assign legal[W] = (w1 & ~n1 & ~s1 | w1 & n1 & rwn | w1 & s1 & rws) & cx[W];
    assign legal[S] = (s1 & ~e1 & ~w1 | s1 & e1 & rse | s1 & w1 & rsw) & cx[S];
    assign local_hit = ~n1 & ~e1 & ~w1 & ~s1;

    always_comb begin
        sel        = '0;
        unroutable = 1'b0;
        if (local_hit) begin
            sel[L_IDX] = 1'b1;
        end else if (legal != 4'b0000) begin
            if (FORK_EN)       sel[3:0] = legal;
            else if (legal[N]) sel[N]   = 1'b1;
            else if (legal[E]) sel[E]   = 1'b1;
            else if (legal[W]) sel[W]   = 1'b1;
            else               sel[S]   = 1'b1;
        end else if (DR_EN && cx[dr]) begin
            sel = port_vec_t'(5'd1 << dr);
        end else begin
            unroutable = 1'b1;
        end
    end

endmodule

// File: rtl/lbdr_dr_fork.sv
// rtl/lbdr_dr_fork.sv - packet-level LBDR router input unit with deroute and fork
module lbdr_dr_fork
    import lbdr_pkg::*;
#(
    parameter int X_W     = 2,
    parameter int Y_W     = 2,
    parameter bit FORK_EN = 1'b0,
    parameter bit DR_EN   = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               empty,
    input  logic [7:0]         Rxy_rst,
    input  logic [3:0]         Cx_rst,
    input  logic [1:0]         dr_rst,
    input  logic [X_W+Y_W-1:0] cur_addr_rst,
    input  logic [2:0]         flit_id,
    input  logic [X_W+Y_W-1:0] dst_addr,
    output logic               Nport,
    output logic               Eport,
    output logic               Wport,
    output logic               Sport,
    output logic               Lport,
    output logic               busy,
    output logic               route_err
);

    localparam int AW = X_W + Y_W;

    logic [7:0]    rxy;
    logic [3:0]    cx;
    logic [1:0]    dr;
    logic [AW-1:0] cur_addr;

    state_e        state, state_next;
    port_vec_t     ports_q, ports_next;
    logic          err_q, err_next;

    port_vec_t     sel;
    logic          unroutable;
    logic          accept, is_hdr, is_tail;

    lbdr_route_calc #(
        .X_W     (X_W),
        .Y_W     (Y_W),
        .FORK_EN (FORK_EN),
        .DR_EN   (DR_EN)
    ) u_calc (
        .rxy        (rxy),
        .cx         (cx),
        .dr         (dr),
        .cur_addr   (cur_addr),
        .dst_addr   (dst_addr),
        .sel        (sel),
        .unroutable (unroutable)
    );

    assign accept  = ~empty;
    assign is_hdr  = |(flit_id & HEADER);
    assign is_tail = |(flit_id & TAIL);

    always_ff @(posedge clk) begin
        if (rst) begin
            rxy      <= Rxy_rst;
            cx       <= Cx_rst;
            dr       <= dr_rst;
            cur_addr <= cur_addr_rst;
            state    <= IDLE;
            ports_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_next;
            ports_q  <= ports_next;
            err_q    <= err_next;
        end
    end

    // LAST shows a single-flit packet for one cycle; inputs are handled as in IDLE
    always_comb begin
        state_next = state;
        ports_next = ports_q;
        err_next   = 1'b0;
        if (state != ROUTED) begin
            state_next = IDLE;
            ports_next = '0;
        end
        if (accept) begin
            if (is_hdr) begin
                if (state == ROUTED) err_next = 1'b1;
                if (unroutable) begin
                    state_next = IDLE;
                    ports_next = '0;
                    err_next   = 1'b1;
                end else begin
                    state_next = is_tail ? LAST : ROUTED;
                    ports_next = sel;
                end
            end else if (state == ROUTED) begin
                if (is_tail) begin
                    state_next = IDLE;
                    ports_next = '0;
                end
            end else begin
                err_next = 1'b1;
            end
        end
    end

    always_comb begin
        {Lport, Sport, Wport, Eport, Nport} = ports_q;
        busy      = (state != IDLE);
        route_err = err_q;
    end

endmodule
